// File: rtl/gsim_pkg.sv
// Shared constants and types for the Gauss-Seidel matrix fetch sequencer.
package gsim_pkg;

   localparam int ROWS           = 16;        // rows per matrix; b sits at word offset ROWS
   localparam int WPM            = ROWS + 1;  // memory words per matrix
   localparam int AW             = 10;        // memory address width
   localparam int DW             = 256;       // memory word width
   localparam int NUM_ITER_DEF   = 20;        // default row sweeps per matrix
   localparam int FIFO_DEPTH_DEF = 4;         // default return-buffer depth

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Tag travelling alongside each outstanding read; MSB-first field order.
   typedef struct packed {
      logic       is_b;
      logic [3:0] row_idx;
      logic [3:0] mat_idx;
      logic       sweep_last;
      logic       last;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/gsim_fetch_fifo.sv
// First-word-fall-through FIFO; head entry is visible on o_data whenever !o_empty.
// DEPTH must be a power of two and at least 2.
module gsim_fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign o_data  = mem_q[rd_ptr_q[PW-1:0]];

   // Pointer advance; pushes into a full FIFO and pops from an empty one are ignored.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_push && !o_full)  wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
      if (i_pop  && !o_empty) rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
   end

   // Pointer registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is data-only and needs no reset; pointers define validity.
   always_ff @(posedge i_clk) begin
      if (i_push && !o_full) mem_q[wr_ptr_q[PW-1:0]] <= i_data;
   end

endmodule

// File: rtl/gsim_fetch_ctrl.sv
// Read sequencer for the Gauss-Seidel matrix memory: per matrix one b word, then
// NUM_ITER sweeps of rows 0..ROWS-1, each word tagged and streamed to the datapath.
// Handshakes: a transfer happens on a cycle where valid && ready are both high at
// the rising edge; a valid (rreq / row_vld) is never withdrawn and its payload never
// changes until that transfer occurs.
module gsim_fetch_ctrl
   import gsim_pkg::*;
#(
   parameter int NUM_ITER   = NUM_ITER_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_module_en,
   input  logic [4:0]    i_matrix_num,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic          o_mem_rreq,
   output logic [AW-1:0] o_mem_addr,
   input  logic          i_mem_rrdy,
   input  logic [DW-1:0] i_mem_dout,
   input  logic          i_mem_dout_vld,
   output logic          o_row_vld,
   input  logic          i_row_rdy,
   output logic [DW-1:0] o_row_data,
   output logic          o_row_is_b,
   output logic [3:0]    o_row_idx,
   output logic [3:0]    o_mat_idx,
   output logic          o_sweep_last,
   output logic          o_last
);

   localparam int SW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      num_q, num_d;
   logic [3:0]      mat_q, mat_d;
   logic [AW-1:0]   base_q, base_d;
   logic [3:0]      row_q, row_d;
   logic [SW-1:0]   sweep_q, sweep_d;
   logic            in_b_q, in_b_d;
   logic            err_q, err_d;

   logic            accept, pop, busy;
   logic            last_row, last_sweep, last_mat;
   logic            tag_full, tag_empty, data_full, data_empty;
   tag_t            req_tag, head_tag;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   head_data;

   assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
   assign last_row   = (row_q == 4'(ROWS - 1));
   assign last_sweep = (sweep_q == SW'(NUM_ITER - 1));
   assign last_mat   = ({1'b0, mat_q} == (num_q - 5'd1));

   // Credit limit keeps accepted-but-unpopped words within the return buffer.
   assign o_mem_rreq = (state_q == ISSUE) && (cnt_q < CW'(FIFO_DEPTH)) && !tag_full;
   assign accept     = o_mem_rreq && i_mem_rrdy;
   assign o_row_vld  = !data_empty && !tag_empty;
   assign pop        = o_row_vld && i_row_rdy;

   // Address and tag of the next request, derived from the sequencing counters.
   always_comb begin
      req_tag            = '0;
      req_tag.is_b       = in_b_q;
      req_tag.row_idx    = in_b_q ? 4'd0 : row_q;
      req_tag.mat_idx    = mat_q;
      req_tag.sweep_last = !in_b_q && last_row && last_sweep;
      req_tag.last       = !in_b_q && last_row && last_sweep && last_mat;
      req_addr           = base_q + (in_b_q ? AW'(ROWS) : {{(AW-4){1'b0}}, row_q});
   end

   assign o_mem_addr = o_mem_rreq ? req_addr : '0;

   gsim_fetch_fifo #(.WIDTH(TAG_W), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (accept),
      .i_data  (req_tag),
      .i_pop   (pop),
      .o_data  (head_tag),
      .o_full  (tag_full),
      .o_empty (tag_empty)
   );

   // Returns are only buffered during a job so stale data after an abort is dropped.
   gsim_fetch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_data_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_mem_dout_vld && busy),
      .i_data  (i_mem_dout),
      .i_pop   (pop),
      .o_data  (head_data),
      .o_full  (data_full),
      .o_empty (data_empty)
   );

   // Stream outputs read zero whenever no word is presented.
   always_comb begin
      o_row_data   = o_row_vld ? head_data : '0;
      o_row_is_b   = o_row_vld && head_tag.is_b;
      o_row_idx    = o_row_vld ? head_tag.row_idx : 4'd0;
      o_mat_idx    = o_row_vld ? head_tag.mat_idx : 4'd0;
      o_sweep_last = o_row_vld && head_tag.sweep_last;
      o_last       = o_row_vld && head_tag.last;
   end

   // Next-state logic: FSM, request sequencing counters, credit and error flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      mat_d   = mat_q;
      base_d  = base_q;
      row_d   = row_q;
      sweep_d = sweep_q;
      in_b_d  = in_b_q;
      err_d   = err_q | (i_mem_dout_vld && data_full);
      o_busy  = busy;
      o_done  = (state_q == DONE);

      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      case (state_q)
         IDLE: begin
            if (i_module_en) begin
               num_d   = i_matrix_num;
               mat_d   = 4'd0;
               base_d  = '0;
               row_d   = 4'd0;
               sweep_d = '0;
               in_b_d  = 1'b1;
               state_d = (i_matrix_num == 5'd0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               if (in_b_q) begin
                  in_b_d  = 1'b0;
                  row_d   = 4'd0;
                  sweep_d = '0;
               end else if (!last_row) begin
                  row_d = row_q + 4'd1;
               end else begin
                  row_d = 4'd0;
                  if (!last_sweep) begin
                     sweep_d = sweep_q + 1'b1;
                  end else if (last_mat) begin
                     state_d = DRAIN;
                  end else begin
                     mat_d   = mat_q + 4'd1;
                     base_d  = base_q + AW'(WPM);
                     sweep_d = '0;
                     in_b_d  = 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         num_q   <= 5'd0;
         mat_q   <= 4'd0;
         base_q  <= '0;
         row_q   <= 4'd0;
         sweep_q <= '0;
         in_b_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         mat_q   <= mat_d;
         base_q  <= base_d;
         row_q   <= row_d;
         sweep_q <= sweep_d;
         in_b_q  <= in_b_d;
         err_q   <= err_d;
      end
   end

   assign o_err = err_q;

endmodule

// File: tb/tb_gsim_fetch_ctrl.sv
// Bench for gsim_fetch_ctrl: memory responder with variable in-order latency,
// scoreboard of expected addresses and tagged words, table of job configurations
// and hand-written sequences for stall, rrdy back-pressure and mid-job reset.
module tb_gsim_fetch_ctrl;

   localparam int NI   = 2;
   localparam int ROWS = 16;
   localparam int WPM  = 17;

   // ---------------- clock / reset / DUT ----------------
   logic         i_clk = 1'b0;
   logic         i_reset = 1'b0;
   logic         i_module_en = 1'b0;
   logic [4:0]   i_matrix_num = 5'd0;
   logic         i_mem_rrdy = 1'b0;
   logic [255:0] i_mem_dout = '0;
   logic         i_mem_dout_vld = 1'b0;
   logic         i_row_rdy = 1'b0;
   logic         o_busy, o_done, o_err, o_mem_rreq, o_row_vld;
   logic [9:0]   o_mem_addr;
   logic [255:0] o_row_data;
   logic         o_row_is_b, o_sweep_last, o_last;
   logic [3:0]   o_row_idx, o_mat_idx;

   always #5 i_clk = ~i_clk;

   gsim_fetch_ctrl #(.NUM_ITER(NI), .FIFO_DEPTH(4)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_module_en    (i_module_en),
      .i_matrix_num   (i_matrix_num),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_err          (o_err),
      .o_mem_rreq     (o_mem_rreq),
      .o_mem_addr     (o_mem_addr),
      .i_mem_rrdy     (i_mem_rrdy),
      .i_mem_dout     (i_mem_dout),
      .i_mem_dout_vld (i_mem_dout_vld),
      .o_row_vld      (o_row_vld),
      .i_row_rdy      (i_row_rdy),
      .o_row_data     (o_row_data),
      .o_row_is_b     (o_row_is_b),
      .o_row_idx      (o_row_idx),
      .o_mat_idx      (o_mat_idx),
      .o_sweep_last   (o_sweep_last),
      .o_last         (o_last)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   logic [9:0]  exp_addr_q[$];
   logic [20:0] exp_word_q[$];   // {is_b, row[3:0], mat[3:0], sweep_last, last, addr[9:0]}

   typedef struct {
      int         due;
      logic [9:0] addr;
   } ret_t;
   ret_t ret_q[$];

   int cyc = 0;
   int accepts_job = 0;
   int pops_job = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_pop_cyc = 0;
   bit rreq_seen = 1'b0;

   // stimulus knobs
   bit rrdy_rand = 1'b0;
   bit rdy_rand  = 1'b0;
   bit rdy_stall = 1'b0;
   int rrdy_low  = 0;
   int lat_min   = 2;
   int lat_max   = 2;

   function automatic logic [255:0] mem_word(input logic [9:0] a);
      return {8{a, 22'h15A5A5}};
   endfunction

   task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected address and word sequence of one job, built from the access order.
   task automatic push_job(input int num);
      int   base;
      logic sl, ls;
      for (int m = 0; m < num; m++) begin
         base = m * WPM;
         exp_addr_q.push_back(10'(base + ROWS));
         exp_word_q.push_back({1'b1, 4'd0, 4'(m), 1'b0, 1'b0, 10'(base + ROWS)});
         for (int s = 0; s < NI; s++) begin
            for (int r = 0; r < ROWS; r++) begin
               sl = (s == NI - 1) && (r == ROWS - 1);
               ls = sl && (m == num - 1);
               exp_addr_q.push_back(10'(base + r));
               exp_word_q.push_back({1'b0, 4'(r), 4'(m), sl, ls, 10'(base + r)});
            end
         end
      end
   endtask

   // ---------------- memory responder / stream sink / monitor ----------------
   // Inputs are chosen at the falling edge; the handshakes they form with the DUT
   // outputs are then observed and take effect at the following rising edge.
   always @(negedge i_clk) begin
      ret_t        r;
      logic [20:0] w;
      if (rrdy_low > 0) begin
         i_mem_rrdy = 1'b0;
         rrdy_low--;
      end else begin
         i_mem_rrdy = rrdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (rdy_stall) i_row_rdy = 1'b0;
      else           i_row_rdy = rdy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
         r = ret_q.pop_front();
         i_mem_dout_vld = 1'b1;
         i_mem_dout     = mem_word(r.addr);
      end else begin
         i_mem_dout_vld = 1'b0;
         i_mem_dout     = '0;
      end
      #1;
      if (o_mem_rreq) rreq_seen = 1'b1;
      if (o_mem_rreq && i_mem_rrdy) begin
         accepts_job++;
         if (exp_addr_q.size() == 0) chk("addr_extra", 1, 0);
         else                        chk("req_addr", o_mem_addr, exp_addr_q.pop_front());
         r.due  = cyc + int'($urandom_range(lat_min, lat_max));
         r.addr = o_mem_addr;
         ret_q.push_back(r);
      end
      if (o_row_vld && i_row_rdy) begin
         pops_job++;
         last_pop_cyc = cyc;
         if (exp_word_q.size() == 0) begin
            chk("word_extra", 1, 0);
         end else begin
            w = exp_word_q.pop_front();
            chk("row_tag", {o_row_is_b, o_row_idx, o_mat_idx, o_sweep_last, o_last}, w[20:10]);
            chk("row_data", o_row_data, mem_word(w[9:0]));
         end
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic start_job(input int num);
      @(negedge i_clk); #2;
      exp_addr_q.delete();
      exp_word_q.delete();
      accepts_job  = 0;
      pops_job     = 0;
      done_cnt     = 0;
      rreq_seen    = 1'b0;
      push_job(num);
      i_module_en  = 1'b1;
      i_matrix_num = 5'(num);
      @(negedge i_clk); #2;
      i_module_en  = 1'b0;
   endtask

   task automatic finish_job(input int num, input int exp_words);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 6000) begin
         @(negedge i_clk); #2;
         n++;
      end
      chk("done_seen", done_cnt != 0, 1);
      @(negedge i_clk); #2;
      chk("word_count", pops_job, exp_words);
      chk("sb_empty", exp_word_q.size() + exp_addr_q.size(), 0);
      chk("done_pulses", done_cnt, 1);
      chk("idle_after", {o_busy, o_done}, 0);
      chk("err_clear", o_err, 0);
      if (num == 0) chk("zero_no_rreq", rreq_seen, 0);
      else          chk("done_after_pop", done_cyc - last_pop_cyc, 2);
   endtask

   // ---------------- test table ----------------
   typedef struct {
      int num;
      bit rrdy_rand;
      bit rdy_rand;
      int lat_min;
      int lat_max;
      int exp_words;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int n;
      vecs[0] = '{num: 1,  rrdy_rand: 1'b0, rdy_rand: 1'b0, lat_min: 2, lat_max: 2, exp_words: 33};
      vecs[1] = '{num: 3,  rrdy_rand: 1'b0, rdy_rand: 1'b0, lat_min: 2, lat_max: 2, exp_words: 99};
      vecs[2] = '{num: 2,  rrdy_rand: 1'b1, rdy_rand: 1'b1, lat_min: 1, lat_max: 4, exp_words: 66};
      vecs[3] = '{num: 16, rrdy_rand: 1'b1, rdy_rand: 1'b0, lat_min: 1, lat_max: 3, exp_words: 528};
      vecs[4] = '{num: 0,  rrdy_rand: 1'b0, rdy_rand: 1'b0, lat_min: 2, lat_max: 2, exp_words: 0};

      // reset state
      i_reset = 1'b0;
      repeat (3) @(negedge i_clk);
      #2;
      chk("reset_outputs", {o_busy, o_done, o_err, o_mem_rreq, o_mem_addr, o_row_vld,
                            o_row_data, o_row_is_b, o_row_idx, o_mat_idx, o_sweep_last, o_last}, 0);
      i_reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         rrdy_rand = vecs[i].rrdy_rand;
         rdy_rand  = vecs[i].rdy_rand;
         lat_min   = vecs[i].lat_min;
         lat_max   = vecs[i].lat_max;
         start_job(vecs[i].num);
         if (vecs[i].num == 0) chk("zero_done_next", o_done, 1);
         finish_job(vecs[i].num, vecs[i].exp_words);
      end

      // datapath stalled: credit caps outstanding reads at the buffer depth
      rrdy_rand = 1'b0;
      rdy_rand  = 1'b0;
      lat_min   = 2;
      lat_max   = 2;
      rdy_stall = 1'b1;
      start_job(1);
      repeat (50) begin
         @(negedge i_clk); #2;
      end
      chk("stall_accepts", accepts_job, 4);
      chk("stall_rreq", o_mem_rreq, 0);
      chk("stall_err", o_err, 0);
      rdy_stall = 1'b0;
      finish_job(1, 33);

      // memory back-pressure mid-issue: request and address held
      start_job(2);
      n = 0;
      while (accepts_job < 5 && n < 200) begin
         @(negedge i_clk); #2;
         n++;
      end
      rrdy_low = 5;
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk); #2;
         chk("hold_rreq", o_mem_rreq, 1);
         chk("hold_addr", o_mem_addr, exp_addr_q[0]);
      end
      finish_job(2, 66);

      // asynchronous reset in the middle of a job, then a clean job
      start_job(2);
      repeat (12) begin
         @(negedge i_clk); #2;
      end
      @(negedge i_clk); #3;
      i_reset = 1'b0;
      #1;
      chk("abort_outputs", {o_busy, o_done, o_err, o_mem_rreq, o_mem_addr, o_row_vld,
                            o_row_data, o_row_is_b, o_row_idx, o_mat_idx, o_sweep_last, o_last}, 0);
      exp_addr_q.delete();
      exp_word_q.delete();
      @(negedge i_clk); #3;
      i_reset = 1'b1;
      n = 0;
      while (ret_q.size() != 0 && n < 50) begin
         @(negedge i_clk); #2;
         n++;
      end
      repeat (3) begin
         @(negedge i_clk); #2;
      end
      chk("abort_idle", {o_row_vld, o_busy, o_err, o_done}, 0);
      chk("abort_no_done", done_cnt, 0);
      start_job(1);
      finish_job(1, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
